// File: rtl/morse_pkg.sv
// Shared constants for the Morse entry path: FSM state codes, symbol-count width
// and the default board timing used by the keyer and the letter-storage stage.
package morse_pkg;

    localparam int SYMBOL_COUNT_W = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_DASH_CYCLES     = 25_000_000;
    localparam int DEF_GAP_CYCLES      = 100_000_000;
    localparam int DEF_MAX_SYMBOLS     = 4;

    typedef logic [0:0] morse_state_t;

    localparam morse_state_t ST_IDLE    = 1'b0;
    localparam morse_state_t ST_PRESSED = 1'b1;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw
// board input; the debounced level is registered.
module morse_debounce
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_meta;
    logic             sync_out;
    logic [CNT_W-1:0] stable_cnt;

    // A single sample agreeing with the current level throws away the run.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
            if (sync_out == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                level      <= sync_out;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse key front end: debounces key and confirm, classifies presses as dot/dash,
// counts symbols per letter. Define MORSE_AUTO_GAP_EN to commit letters after an idle gap.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DASH_CYCLES     = DEF_DASH_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int MAX_SYMBOLS     = DEF_MAX_SYMBOLS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      morse1,
    input  logic                      confirm,
    output logic                      dot,
    output logic                      dash,
    output logic                      letter_done,
    output logic [SYMBOL_COUNT_W-1:0] symbol_count,
    output logic                      overflow,
    output logic                      key_active
);

    localparam int PRESS_W = $clog2(DASH_CYCLES + 1);
    localparam logic [SYMBOL_COUNT_W-1:0] MAX_COUNT = SYMBOL_COUNT_W'(MAX_SYMBOLS);

    if (MAX_SYMBOLS < 1 || MAX_SYMBOLS > 7 || DASH_CYCLES < 1 ||
        GAP_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("morse_keyer: parameter out of range");
    end

    logic               key_level;
    logic               confirm_level;
    logic               key_prev;
    logic               confirm_prev;
    morse_state_t       state;
    logic [PRESS_W-1:0] press_cnt;
    logic               commit_pending;

    logic key_rise;
    logic key_fall;
    logic confirm_rise;
    logic symbol_event;
    logic is_dash;
    logic gap_fire;
    logic commit_req;
    logic do_commit;

    morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (morse1),
        .level (key_level)
    );

    morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (confirm),
        .level (confirm_level)
    );

    assign key_active   = key_level;
    assign key_rise     = key_level & ~key_prev;
    assign key_fall     = ~key_level & key_prev;
    assign confirm_rise = confirm_level & ~confirm_prev;
    assign symbol_event = (state == ST_PRESSED) && key_fall;
    assign is_dash      = press_cnt >= PRESS_W'(DASH_CYCLES);
    assign commit_req   = confirm_rise | gap_fire;

    // A commit landing on a symbol cycle waits one cycle so the letter includes it.
    assign do_commit = ((commit_req && !symbol_event) || commit_pending) &&
                       (symbol_count != '0);

`ifdef MORSE_AUTO_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_run;

    assign gap_run  = (state == ST_IDLE) && (symbol_count != '0);
    assign gap_fire = gap_run && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Saturates at GAP_CYCLES so an unattended letter is committed only once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if (key_rise || symbol_event || do_commit) begin
            gap_cnt <= '0;
        end else if (gap_run && gap_cnt != GAP_W'(GAP_CYCLES)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end
`else
    assign gap_fire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            key_prev       <= 1'b0;
            confirm_prev   <= 1'b0;
            state          <= ST_IDLE;
            press_cnt      <= '0;
            commit_pending <= 1'b0;
            dot            <= 1'b0;
            dash           <= 1'b0;
            letter_done    <= 1'b0;
            symbol_count   <= '0;
            overflow       <= 1'b0;
        end else begin
            key_prev       <= key_level;
            confirm_prev   <= confirm_level;
            commit_pending <= commit_req && symbol_event;
            dot            <= 1'b0;
            dash           <= 1'b0;
            letter_done    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (key_rise) begin
                        state     <= ST_PRESSED;
                        press_cnt <= PRESS_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (key_fall) begin
                        state     <= ST_IDLE;
                        press_cnt <= '0;
                    end else if (press_cnt != PRESS_W'(DASH_CYCLES)) begin
                        press_cnt <= press_cnt + PRESS_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    press_cnt <= '0;
                end
            endcase

            if (symbol_event) begin
                if (symbol_count < MAX_COUNT) begin
                    dot          <= !is_dash;
                    dash         <= is_dash;
                    symbol_count <= symbol_count + SYMBOL_COUNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end else if (do_commit) begin
                letter_done  <= 1'b1;
                symbol_count <= '0;
                overflow     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: directed and random key presses scored
// against a press-length / letter-count model.
module tb_morse_keyer;

    localparam int DEB  = 4;
    localparam int DASH = 20;
    localparam int GAP  = 50;
    localparam int MAXS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       morse1 = 1'b0;
    logic       confirm = 1'b0;
    logic       dot;
    logic       dash;
    logic       letter_done;
    logic [2:0] symbol_count;
    logic       overflow;
    logic       key_active;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int dot_seen = 0, dash_seen = 0, letter_seen = 0;
    int last_dot_cyc = -1, last_dash_cyc = -1, last_letter_cyc = -1;
    int ka_high = 0, ka_rise = 0, ka_fall = 0;
    logic ka_prev = 1'b0;

    int exp_dots = 0, exp_dashes = 0, exp_letters = 0, exp_count = 0, exp_overflow = 0;

    morse_keyer #(
        .DEBOUNCE_CYCLES (DEB),
        .DASH_CYCLES     (DASH),
        .GAP_CYCLES      (GAP),
        .MAX_SYMBOLS     (MAXS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .morse1       (morse1),
        .confirm      (confirm),
        .dot          (dot),
        .dash         (dash),
        .letter_done  (letter_done),
        .symbol_count (symbol_count),
        .overflow     (overflow),
        .key_active   (key_active)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Strobe log, sampled on the falling edge.
    always @(negedge clock) begin
        if (dot === 1'b1) begin dot_seen++; last_dot_cyc = cyc; end
        if (dash === 1'b1) begin dash_seen++; last_dash_cyc = cyc; end
        if (letter_done === 1'b1) begin letter_seen++; last_letter_cyc = cyc; end
        if (key_active === 1'b1) ka_high++;
        if (key_active === 1'b1 && ka_prev === 1'b0) ka_rise++;
        if (key_active === 1'b0 && ka_prev === 1'b1) ka_fall++;
        ka_prev = key_active;
        if (cyc > 2) begin
            checks++;
            assert (($countones({dot, dash, letter_done}) <= 1) === 1'b1) else begin
                errors++;
                $error("[TB] FAIL strobe_exclusive: observed dot=%b dash=%b letter_done=%b, expected at most one high",
                       dot, dash, letter_done);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_dots"}, dot_seen, exp_dots);
        check_output({tag, "_dashes"}, dash_seen, exp_dashes);
        check_output({tag, "_letters"}, letter_seen, exp_letters);
        check_output({tag, "_count"}, int'(symbol_count), exp_count);
        check_output({tag, "_overflow"}, int'(overflow), exp_overflow);
    endtask

    // Clean press of len cycles; the debounced press is len cycles long, and
    // the strobe appears DEB+3 edges after the release is first sampled.
    task automatic press(input int len);
        int c;
        morse1 = 1'b1;
        tick(len);
        c = cyc;
        morse1 = 1'b0;
        tick(DEB + 8);
        if (exp_count < MAXS) begin
            exp_count++;
            if (len < DASH) begin
                exp_dots++;
                check_output("dot_latency", last_dot_cyc, c + 4 + DEB);
            end else begin
                exp_dashes++;
                check_output("dash_latency", last_dash_cyc, c + 4 + DEB);
            end
        end else begin
            exp_overflow = 1;
        end
    endtask

    task automatic confirm_pulse();
        int c;
        c = cyc;
        confirm = 1'b1;
        tick(8);
        confirm = 1'b0;
        tick(DEB + 6);
        if (exp_count > 0) begin
            exp_letters++;
            exp_count = 0;
            exp_overflow = 0;
            check_output("letter_latency", last_letter_cyc, c + 4 + DEB);
        end
    endtask

    initial begin
        int lv[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int du[10] = '{3, 1, 3, 1, 8, 3, 1, 3, 1, 15};
        int snap, snap2, c;

        $display("[TB] starting morse_keyer bench");
        tick(3);
        check_output("reset_dot", int'(dot), 0);
        check_output("reset_dash", int'(dash), 0);
        check_output("reset_letter_done", int'(letter_done), 0);
        check_output("reset_overflow", int'(overflow), 0);
        check_output("reset_key_active", int'(key_active), 0);
        check_output("reset_count", int'(symbol_count), 0);
        reset = 1'b1;
        tick(2);

        snap = ka_high;
        press(10);
        check_output("dot_key_active_cycles", ka_high - snap, 10);
        check_model("clean_dot");
        confirm_pulse();

        press(30);
        press(1000);
        check_model("two_dashes");
        confirm_pulse();

        press(19);
        press(20);
        check_model("dash_boundary");
        confirm_pulse();

        snap = ka_rise;
        snap2 = ka_fall;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) c = cyc;
            morse1 = lv[i][0];
            tick(du[i]);
        end
        tick(4);
        exp_dots++;
        exp_count++;
        check_output("glitch_dot_latency", last_dot_cyc, c + 4 + DEB);
        check_output("glitch_key_rises", ka_rise - snap, 1);
        check_output("glitch_key_falls", ka_fall - snap2, 1);
        check_model("glitch_press");
        confirm_pulse();

        for (int i = 0; i < 5; i++) press(8);
        check_model("five_dots");
        confirm_pulse();
        check_model("after_commit");

        confirm_pulse();
        check_model("empty_confirm");

        morse1 = 1'b1;
        tick(10);
        c = cyc;
        morse1 = 1'b0;
        confirm = 1'b1;
        tick(8);
        confirm = 1'b0;
        tick(10);
        exp_dots++;
        exp_letters++;
        check_output("same_edge_dot", last_dot_cyc, c + 4 + DEB);
        check_output("same_edge_letter", last_letter_cyc, c + 5 + DEB);
        check_model("same_edge");

        press(10);
        morse1 = 1'b1;
        tick(8);
        reset = 1'b0;
        tick(1);
        check_output("midreset_key_active", int'(key_active), 0);
        check_output("midreset_count", int'(symbol_count), 0);
        check_output("midreset_strobes", int'(dot) + int'(dash) + int'(letter_done), 0);
        check_output("midreset_overflow", int'(overflow), 0);
        tick(2);
        morse1 = 1'b0;
        reset = 1'b1;
        tick(20);
        exp_count = 0;
        exp_overflow = 0;
        check_model("mid_reset");

        for (int i = 0; i < 16; i++) begin
            press($urandom_range(6, 40));
            tick($urandom_range(0, 8));
            if ($urandom_range(0, 2) == 0) confirm_pulse();
        end
        check_model("random_presses");
        confirm_pulse();

        press(8);
        tick(70);
`ifdef MORSE_AUTO_GAP_EN
        exp_letters++;
        exp_count = 0;
`endif
        check_model("idle_gap");
        confirm_pulse();
        check_model("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Front-end conditioner for the Morse entry path. Synchronises and debounces the raw `morse1` key and `confirm` button, and classifies each key press as a dot or a dash by its held duration. Emits single-cycle `dot`, `dash` and `letter_done` strobes plus a per-letter symbol count. Sits between the board pins and the Morse shift/letter-storage stage, which consumes the strobes on the same `clock`.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised samples required before a level change is accepted.
- `DASH_CYCLES`, 25_000_000: debounced press length at or above which a press is a dash.
- `GAP_CYCLES`, 100_000_000: idle length that auto-terminates a letter (used only with `MORSE_AUTO_GAP_EN`).
- `MAX_SYMBOLS`, 4: maximum symbols per letter (4 dashes = 16 bits downstream).
- `clock  in  1`: single system clock; all logic on the rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `morse1  in  1`: raw key, asynchronous, bouncy.
- `confirm  in  1`: raw letter-commit button, asynchronous, bouncy.
- `dot  out  1`: one-cycle strobe, short press accepted.
- `dash  out  1`: one-cycle strobe, long press accepted.
- `letter_done  out  1`: one-cycle strobe, current letter committed.
- `symbol_count  out  3`: symbols accepted in the current letter, 0..MAX_SYMBOLS.
- `overflow  out  1`: sticky; a symbol was dropped because the letter was full.
- `key_active  out  1`: debounced key level (for an LED).

## Operation
- Each raw input passes through a 2-flop synchroniser, then a debouncer. The debounced level toggles only after the synchronised value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any disagreeing sample restarts the count.
- The FSM has two states, IDLE and PRESSED.
  - IDLE -> PRESSED on a debounced key rising edge. The press counter loads 1.
  - In PRESSED, the counter increments each cycle and saturates at `DASH_CYCLES`. Its width is clog2(DASH_CYCLES+1).
  - PRESSED -> IDLE on a debounced key falling edge. The block classifies the press from the press length L:
    - L < `DASH_CYCLES`: pulse `dot`.
    - Otherwise: pulse `dash`.
  - Exactly one of `dot`/`dash` fires per press.
- Symbol acceptance:
  - If `symbol_count` < `MAX_SYMBOLS`: emit the strobe and increment the count.
  - Otherwise: no strobe; set `overflow`.
- Commit: a debounced `confirm` rising edge with `symbol_count` > 0 pulses `letter_done`. The next cycle, `symbol_count` = 0 and `overflow` = 0.
- A `confirm` edge with `symbol_count` = 0 is ignored, so no empty letters are committed.
- A `confirm` edge during PRESSED commits the letter. The in-progress press belongs to the next letter.
- If a symbol strobe and a commit would occur in the same cycle, the symbol is emitted first. `letter_done` follows on the next cycle and includes that symbol.
- `dot`, `dash` and `letter_done` are never asserted in the same cycle.

## Timing
- While `reset` = 0 at a clock edge, all of the following hold on the next cycle:
  - `dot`, `dash`, `letter_done`, `overflow` and `key_active` are 0, and `symbol_count` = 0.
  - The FSM is in IDLE, and all counters and synchroniser/debouncer state are 0.
- Reset mid-press discards the press. A key still held after reset is accepted as a new press once debounced.
- Latency from a raw edge first sampled at edge N:
  - The debounced level changes at edge N+2+`DEBOUNCE_CYCLES`.
  - The resulting strobe (`dot`/`dash`/`letter_done`) is high during the cycle after edge N+3+`DEBOUNCE_CYCLES`.
- `key_active` equals the debounced level, which is registered with no extra delay.
- Every strobe is high for exactly one cycle. The downstream stage samples strobes on `clock` with no handshake and no back-pressure.
- The press counter saturates, so an arbitrarily long press is still exactly one dash.

## Configuration
- `MORSE_AUTO_GAP_EN` defined:
  - An idle counter runs in IDLE while `symbol_count` > 0. It clears on any key press, symbol or commit.
  - Reaching `GAP_CYCLES` commits exactly as a `confirm` edge would (`letter_done` pulse, count clear).
  - The counter saturates after firing, so it fires once per letter.
- `MORSE_AUTO_GAP_EN` undefined: there is no idle counter, `GAP_CYCLES` is unused, and only `confirm` commits a letter.

## Structure
- Package `morse_pkg` holds:
  - the FSM state enum (IDLE, PRESSED);
  - the `SYMBOL_COUNT_W` = 3 constant;
  - the default timing constants shared with the storage stage.
- Sub-module `morse_debounce` contains the synchroniser, the stable counter and the debounced level register. It has parameter `DEBOUNCE_CYCLES` and is instantiated twice, once for `morse1` and once for `confirm`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, DASH_CYCLES=20, GAP_CYCLES=50, MAX_SYMBOLS=4.
- Clean 10-cycle press -> one `dot` pulse; `symbol_count` = 1; `key_active` high for 10 cycles.
- Clean 30-cycle press, then a 1000-cycle press -> two `dash` pulses; `symbol_count` = 2.
- Press with 3-cycle glitches on both edges -> no extra strobes; `key_active` has exactly one rising and one falling edge.
- Five dot presses, then `confirm` -> 4 `dot` pulses; `overflow` = 1 after the fifth; `letter_done` once; then `symbol_count` = 0 and `overflow` = 0.
- `confirm` with count 0 -> no `letter_done`. Key release and `confirm` debounced on the same edge -> `dot`, then `letter_done` the next cycle.
- `reset` low mid-press (cycle 8) -> all outputs 0, no strobe. With `MORSE_AUTO_GAP_EN`: one dot, then 50 idle cycles -> a single `letter_done`.
